sync_fifo: RTL and testbench



---
 rtl/seq_pkg.sv | 20 ++
 rtl/fifo_mem.sv | 41 ++++
 rtl/sync_fifo.sv | 98 +++++++++
 tb/tb_sync_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared constants and helpers for the sequential data-path blocks.
package seq_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 8;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register-array storage with a synchronous write port
// and a registered read port that holds its value between reads.
module fifo_mem #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // NOTE: the storage array has no reset; stale words are unreachable
    // once the pointers are cleared, and a reset here would block RAM mapping.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // NOTE: non-blocking assignments make a same-edge read of the slot
    // being written return the old word, which the full-FIFO case relies on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, registered full/empty/count
// flags and one-cycle overflow/underflow pulses for rejected requests.
module sync_fifo
    import seq_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_en,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic              o_rd_valid,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_rd_valid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_rd_ok;
    logic              w_wr_ok;
    logic [ADDR_W:0]   w_count_next;

    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign w_rd_ok = i_rd_en & ~r_empty;
    assign w_wr_ok = i_wr_en & (~r_full | w_rd_ok);

    // NOTE: default assigned first so every path drives w_count_next (no latch).
    always_comb begin
        w_count_next = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_rd_valid  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count     <= w_count_next;
            r_full      <= (w_count_next == FULL_COUNT);
            r_empty     <= (w_count_next == '0);
            r_rd_valid  <= w_rd_ok;
            r_overflow  <= i_wr_en & ~w_wr_ok;
            r_underflow <= i_rd_en & r_empty;
        end
    end

    fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr_ok),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd_ok),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (o_rd_data)
    );

    assign o_rd_valid  = r_rd_valid;
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (WIDTH=4, DEPTH=4) with a queue-based
// reference model and a scoreboard of expected read words.
module tb_sync_fifo;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_wr_en;
    logic [W-1:0] i_wr_data;
    logic         i_rd_en;
    logic [W-1:0] o_rd_data;
    logic         o_rd_valid;
    logic         o_full;
    logic         o_empty;
    logic [2:0]   o_count;
    logic         o_overflow;
    logic         o_underflow;

    int tests = 0;
    int fails = 0;

    logic [W-1:0] model_q [$];   // words the FIFO should currently hold
    logic [W-1:0] exp_q   [$];   // words expected on upcoming o_rd_valid pulses
    logic [W-1:0] got_q   [$];   // words observed on o_rd_valid pulses
    logic [W-1:0] last_data;
    int           max_count;

    always #5 clk = ~clk;

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_wr_en     (i_wr_en),
        .i_wr_data   (i_wr_data),
        .i_rd_en     (i_rd_en),
        .o_rd_data   (o_rd_data),
        .o_rd_valid  (o_rd_valid),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_flags(input string tag, input logic e_valid, input logic e_ovf, input logic e_unf);
        int sz;
        sz = model_q.size();
        check({tag, "_count"}, 32'(o_count), 32'(sz));
        check({tag, "_full"}, 32'(o_full), 32'(sz == D));
        check({tag, "_empty"}, 32'(o_empty), 32'(sz == 0));
        check({tag, "_valid"}, 32'(o_rd_valid), 32'(e_valid));
        check({tag, "_ovf"}, 32'(o_overflow), 32'(e_ovf));
        check({tag, "_unf"}, 32'(o_underflow), 32'(e_unf));
        if (32'(o_count) > 32'(max_count)) max_count = int'(o_count);
    endtask

    // One clock of stimulus; the model decides acceptance before the edge.
    task automatic step(input string tag, input logic wr, input logic [W-1:0] d, input logic rd);
        logic rd_ok, wr_ok, e_ovf, e_unf;
        int   sz;
        sz    = model_q.size();
        rd_ok = rd && (sz > 0);
        wr_ok = wr && ((sz < D) || rd_ok);
        e_ovf = wr && !wr_ok;
        e_unf = rd && (sz == 0);
        if (rd_ok) exp_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        i_wr_en   = wr;
        i_wr_data = d;
        i_rd_en   = rd;
        @(posedge clk);
        #1;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        check_flags(tag, rd_ok, e_ovf, e_unf);
        if (o_rd_valid && exp_q.size() > 0) begin
            last_data = exp_q.pop_front();
            got_q.push_back(o_rd_data);
        end
        check({tag, "_rd_data"}, 32'(o_rd_data), 32'(last_data));
    endtask

    task automatic do_reset(input string tag, input int cycles, input logic wr, input logic rd);
        i_rst   = 1'b1;
        i_wr_en = wr;
        i_rd_en = rd;
        i_wr_data = 4'hF;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            model_q.delete();
            exp_q.delete();
            last_data = '0;
            check_flags(tag, 1'b0, 1'b0, 1'b0);
            check({tag, "_rd_data"}, 32'(o_rd_data), 32'h0);
        end
        i_rst   = 1'b0;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
    endtask

    task automatic check_got4(input string tag, input logic [W-1:0] e [4]);
        check({tag, "_n"}, 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) check($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(e[i]));
        end
        got_q.delete();
    endtask

    initial begin
        i_rst     = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_data = '0;
        i_rd_en   = 1'b0;
        last_data = '0;
        max_count = 0;

        // Reset holds against active requests, then stays empty after release.
        do_reset("rst", 2, 1'b1, 1'b1);
        step("rst_rel", 1'b0, 4'h0, 1'b0);

        // Fill, overflow attempt, drain.
        step("fill", 1'b1, 4'd1, 1'b0);
        step("fill", 1'b1, 4'd2, 1'b0);
        step("fill", 1'b1, 4'd3, 1'b0);
        step("fill", 1'b1, 4'd4, 1'b0);
        check("full_after_fill", 32'(o_full), 32'd1);
        check("count_after_fill", 32'(o_count), 32'd4);
        step("ovf", 1'b1, 4'd9, 1'b0);
        check("ovf_pulse", 32'(o_overflow), 32'd1);
        step("ovf_gone", 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) step("drain", 1'b0, 4'h0, 1'b1);
        check_got4("drain", '{4'd1, 4'd2, 4'd3, 4'd4});
        check("empty_after_drain", 32'(o_empty), 32'd1);

        // Underflow keeps the last read word.
        step("unf", 1'b0, 4'h0, 1'b1);
        check("unf_pulse", 32'(o_underflow), 32'd1);
        check("unf_hold", 32'(o_rd_data), 32'd4);
        step("unf_gone", 1'b0, 4'h0, 1'b0);

        // Full with simultaneous read and write.
        for (int i = 1; i <= 4; i++) step("fill2", 1'b1, 4'(i), 1'b0);
        step("full_rw", 1'b1, 4'd5, 1'b1);
        check("full_rw_count", 32'(o_count), 32'd4);
        check("full_rw_data", 32'(o_rd_data), 32'd1);
        got_q.delete();
        for (int i = 0; i < 4; i++) step("drain2", 1'b0, 4'h0, 1'b1);
        check_got4("drain2", '{4'd2, 4'd3, 4'd4, 4'd5});

        // Empty with simultaneous read and write.
        step("empty_rw", 1'b1, 4'd7, 1'b1);
        check("empty_rw_unf", 32'(o_underflow), 32'd1);
        check("empty_rw_count", 32'(o_count), 32'd1);
        step("empty_rw_rd", 1'b0, 4'h0, 1'b1);
        check("empty_rw_data", 32'(o_rd_data), 32'd7);
        got_q.delete();

        // Streaming with reads lagging two cycles; pointers wrap twice.
        max_count = 0;
        for (int c = 0; c < 12; c++) begin
            step("wrap", c < 10, 4'((c + 3) % 16), c >= 2);
        end
        check("wrap_n", 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < got_q.size()) check($sformatf("wrap_%0d", i), 32'(got_q[i]), 32'(i + 3));
        end
        check("wrap_max_le3", 32'(max_count <= 3), 32'd1);
        got_q.delete();

        // Reset with data queued discards it.
        for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 4'(8 + i), 1'b0);
        do_reset("mid_rst", 1, 1'b0, 1'b0);
        step("post_wr", 1'b1, 4'd6, 1'b0);
        step("post_rd", 1'b0, 4'h0, 1'b1);
        check("post_rd_data", 32'(o_rd_data), 32'd6);
        check("post_rd_count", 32'(o_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
